// File: rtl/alu_pkg.sv
// Shared command encodings for the ALU family (datapath ALU and branch comparator).
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_cmd_t;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } branch_alu_cmd_t;

    localparam int XLEN = 32;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; encodings outside alu_cmd_t produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]      cmd,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt_s;

    assign shamt_s = rhs[4:0];

    // Operation select
    always_comb begin
        result = 32'd0;
        case (cmd)
            ALU_ADD:  result = lhs + rhs;
            ALU_SUB:  result = lhs - rhs;
            ALU_SLL:  result = lhs << shamt_s;
            ALU_SLT:  result = {31'd0, $signed(lhs) < $signed(rhs)};
            ALU_SLTU: result = {31'd0, lhs < rhs};
            ALU_XOR:  result = lhs ^ rhs;
            ALU_SRL:  result = lhs >> shamt_s;
            ALU_SRA:  result = 32'($signed(lhs) >>> shamt_s);
            ALU_OR:   result = lhs | rhs;
            ALU_AND:  result = lhs & rhs;
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters with a single
// registered response slot that can drain and refill in the same cycle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0][3:0]       req_cmd_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_lhs_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_rhs_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [XLEN-1:0]               rsp_data_o
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr_r;
    logic [PW-1:0]      owner_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [XLEN-1:0]    rsp_data_r;

    logic [PW-1:0]      grant_idx_s;
    logic [PW-1:0]      cand_s;
    logic [PW-1:0]      ptr_next_s;
    logic               grant_any_s;
    logic               slot_free_s;
    logic               transfer_s;
    logic               drain_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [XLEN-1:0]    alu_result_s;
    int                 cand_sum_s;

    // First valid requester at or after the pointer, wrapping around
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        cand_sum_s  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum_s = int'(ptr_r) + i;
            if (cand_sum_s >= NUM_REQ) begin
                cand_sum_s = cand_sum_s - NUM_REQ;
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_s = PW'(cand_sum_s);
            if (!grant_any_s && req_valid_i[cand_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    assign drain_s     = (|rsp_valid_r) && rsp_ready_i[owner_r];
    assign slot_free_s = !(|rsp_valid_r) || rsp_ready_i[owner_r];
    assign transfer_s  = slot_free_s && grant_any_s && !rst_i;
    assign ptr_next_s  = (grant_idx_s == PW'(NUM_REQ - 1)) ? '0 : grant_idx_s + PW'(1);

    // One-hot accept; held low throughout reset
    always_comb begin
        ready_s = '0;
        if (transfer_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign req_ready_o = ready_s;

    alu u_alu (
        .cmd    (req_cmd_i[grant_idx_s]),
        .lhs    (req_lhs_i[grant_idx_s]),
        .rhs    (req_rhs_i[grant_idx_s]),
        .result (alu_result_s)
    );

    // Response slot, owner and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_r       <= '0;
            owner_r     <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= 32'd0;
        end else if (transfer_s) begin
            ptr_r       <= ptr_next_s;
            owner_r     <= grant_idx_s;
            rsp_valid_r <= NUM_REQ'(1) << grant_idx_s;
            rsp_data_r  <= alu_result_s;
        end else if (drain_s) begin
            rsp_valid_r <= '0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign rsp_valid_o = rsp_valid_r;
    assign rsp_data_o  = rsp_data_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench: a 2-requester arbiter plus a 3-requester one for pointer wrap.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]        vld, rdy, ready, rvalid;
    logic [1:0][3:0]   cmd;
    logic [1:0][31:0]  lhs, rhs;
    logic [31:0]       data;

    logic [2:0]        vld3, rdy3, ready3, rvalid3;
    logic [2:0][3:0]   cmd3;
    logic [2:0][31:0]  lhs3, rhs3;
    logic [31:0]       data3;

    int checks = 0;
    int errors = 0;

    logic [3:0]  op_cmd [4];
    logic [31:0] op_lhs [4];
    logic [31:0] op_rhs [4];
    logic [31:0] op_exp [4];

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(vld), .req_ready_o(ready),
        .req_cmd_i(cmd), .req_lhs_i(lhs), .req_rhs_i(rhs),
        .rsp_valid_o(rvalid), .rsp_ready_i(rdy), .rsp_data_o(data)
    );

    alu_arbiter #(.NUM_REQ(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(vld3), .req_ready_o(ready3),
        .req_cmd_i(cmd3), .req_lhs_i(lhs3), .req_rhs_i(rhs3),
        .rsp_valid_o(rvalid3), .rsp_ready_i(rdy3), .rsp_data_o(data3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vld = 2'b11; rdy = 2'b11; cmd = '0; lhs = '0; rhs = '0;
        vld3 = 3'b000; rdy3 = 3'b111; cmd3 = '0; lhs3 = '0; rhs3 = '0;

        // reset holds everything low even with requests pending
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_ready", {30'd0, ready}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
        chk("rst_data", data, 32'd0);

        // first add after reset release
        @(negedge clk);
        rst = 1'b0;
        vld = 2'b01; cmd[0] = ALU_ADD; lhs[0] = 32'd5; rhs[0] = 32'd7;
        #1 chk("add_ready", {30'd0, ready}, 32'd1);
        @(negedge clk);
        chk("add_rvalid", {30'd0, rvalid}, 32'd1);
        chk("add_data", data, 32'd12);

        // both valid, alternating grants, no bubbles (pointer now 1)
        vld = 2'b11;
        lhs[0] = 32'd1;  rhs[0] = 32'd1;
        cmd[1] = ALU_ADD; lhs[1] = 32'd10; rhs[1] = 32'd20;
        for (int i = 0; i < 4; i++) begin
            #1 chk("rr_ready", {30'd0, ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
            @(negedge clk);
            chk("rr_rvalid", {30'd0, rvalid}, (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("rr_data", data, (i % 2 == 0) ? 32'd30 : 32'd2);
        end

        // drain with no request: data retained
        vld = 2'b00;
        #1 chk("idle_ready", {30'd0, ready}, 32'd0);
        @(negedge clk);
        chk("drain_rvalid", {30'd0, rvalid}, 32'd0);
        chk("drain_data", data, 32'd2);

        // port1 sub 0-1, then backpressure for three cycles
        vld = 2'b10; cmd[1] = ALU_SUB; lhs[1] = 32'd0; rhs[1] = 32'd1;
        #1 chk("sub_ready", {30'd0, ready}, 32'd2);
        @(negedge clk);
        chk("sub_rvalid", {30'd0, rvalid}, 32'd2);
        chk("sub_data", data, 32'hFFFF_FFFF);
        vld = 2'b01; rdy = 2'b01;
        cmd[0] = ALU_XOR; lhs[0] = 32'h0000_00F0; rhs[0] = 32'h0000_000F;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", {30'd0, ready}, 32'd0);
            @(negedge clk);
            chk("stall_rvalid", {30'd0, rvalid}, 32'd2);
            chk("stall_data", data, 32'hFFFF_FFFF);
        end
        rdy = 2'b10;
        #1 chk("refill_ready", {30'd0, ready}, 32'd1);
        @(negedge clk);
        chk("refill_rvalid", {30'd0, rvalid}, 32'd1);
        chk("refill_data", data, 32'h0000_00FF);

        // ALU corner cases on port0
        rdy = 2'b11;
        op_cmd[0] = 4'hF;     op_lhs[0] = 32'd5;          op_rhs[0] = 32'd7;          op_exp[0] = 32'd0;
        op_cmd[1] = ALU_SLTU; op_lhs[1] = 32'd1;          op_rhs[1] = 32'hFFFF_FFFF;  op_exp[1] = 32'd1;
        op_cmd[2] = ALU_SLT;  op_lhs[2] = 32'd1;          op_rhs[2] = 32'hFFFF_FFFF;  op_exp[2] = 32'd0;
        op_cmd[3] = ALU_SRA;  op_lhs[3] = 32'h8000_0000;  op_rhs[3] = 32'h0000_0024;  op_exp[3] = 32'hF800_0000;
        for (int i = 0; i < 4; i++) begin
            cmd[0] = op_cmd[i]; lhs[0] = op_lhs[i]; rhs[0] = op_rhs[i];
            #1 chk("op_ready", {30'd0, ready}, 32'd1);
            @(negedge clk);
            chk("op_rvalid", {30'd0, rvalid}, 32'd1);
            chk("op_data", data, op_exp[i]);
        end

        // async reset while FULL (pointer was 1)
        rdy = 2'b00; vld = 2'b11;
        cmd[0] = ALU_ADD; lhs[0] = 32'd5; rhs[0] = 32'd7;
        #2 rst = 1'b1;
        #1;
        chk("arst_rvalid", {30'd0, rvalid}, 32'd0);
        chk("arst_data", data, 32'd0);
        chk("arst_ready", {30'd0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0; rdy = 2'b11;
        #1 chk("post_rst_ready", {30'd0, ready}, 32'd1);
        @(negedge clk);
        chk("post_rst_rvalid", {30'd0, rvalid}, 32'd1);
        chk("post_rst_data", data, 32'd12);
        vld = 2'b00;

        // three requesters: pointer wrap from port2 back to port0
        vld3 = 3'b001; cmd3[0] = ALU_ADD; lhs3[0] = 32'd1; rhs3[0] = 32'd2;
        #1 chk("n3_ready0", {29'd0, ready3}, 32'd1);
        @(negedge clk);
        chk("n3_rvalid0", {29'd0, rvalid3}, 32'd1);
        chk("n3_data0", data3, 32'd3);
        vld3 = 3'b100; cmd3[2] = ALU_SUB; lhs3[2] = 32'd10; rhs3[2] = 32'd3;
        #1 chk("n3_ready2", {29'd0, ready3}, 32'd4);
        @(negedge clk);
        chk("n3_rvalid2", {29'd0, rvalid3}, 32'd4);
        chk("n3_data2", data3, 32'd7);
        vld3 = 3'b011; cmd3[1] = ALU_OR; lhs3[1] = 32'd8; rhs3[1] = 32'd1;
        #1 chk("n3_wrap_ready", {29'd0, ready3}, 32'd1);
        @(negedge clk);
        chk("n3_wrap_rvalid", {29'd0, rvalid3}, 32'd1);
        chk("n3_wrap_data", data3, 32'd3);
        vld3 = 3'b000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
